// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce synchronizer slice.
// The optional preset input is enabled with DEBOUNCE_PRESET_EN.
package debounce_pkg;
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    CHECK_HIGH  = 2'b01,
    STABLE_HIGH = 2'b10,
    CHECK_LOW   = 2'b11
  } db_state_t;

  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int DEBOUNCE_CYCLES_MIN = 2;
endpackage

// File: rtl/debounce_synchronizer_sync_chain.sv
// Plain flop chain bringing an async input into the clock domain.
// With DEBOUNCE_PRESET_EN the chain also has an async set (reset wins).
module sync_chain
  import debounce_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_MIN
) (
  input  logic i_clk,
  input  logic i_rst_n,
`ifdef DEBOUNCE_PRESET_EN
  input  logic i_set_n,
`endif
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;

`ifdef DEBOUNCE_PRESET_EN
  always_ff @(posedge i_clk or negedge i_rst_n or negedge i_set_n) begin
    if (!i_rst_n)     r_chain <= '0;
    else if (!i_set_n) r_chain <= '1;
    else              r_chain <= {r_chain[STAGES-2:0], i_d};
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], i_d};
  end
`endif

  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/debounce_synchronizer.sv
// Synchronise + debounce an async input; clean level and one-cycle edge pulses.
// Define DEBOUNCE_PRESET_EN to add the async active-low preset_neg input.
module debounce_synchronizer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock_pos,
  input  logic reset_neg,
`ifdef DEBOUNCE_PRESET_EN
  input  logic preset_neg,
`endif
  input  logic signal_in,
  output logic signal_out,
  output logic signal_out_neg,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int COUNT_WIDTH = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("debounce_synchronizer: SYNC_STAGES out of range 2..4");
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_deb
    $error("debounce_synchronizer: DEBOUNCE_CYCLES below minimum of 2");
  end

  logic                   w_sync;
  db_state_t              r_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clock_pos),
    .i_rst_n (reset_neg),
`ifdef DEBOUNCE_PRESET_EN
    .i_set_n (preset_neg),
`endif
    .i_d     (signal_in),
    .o_q     (w_sync)
  );

  // r_count holds how many consecutive new-level samples have been seen in CHECK_*.
`ifdef DEBOUNCE_PRESET_EN
  always_ff @(posedge clock_pos or negedge reset_neg or negedge preset_neg) begin
`else
  always_ff @(posedge clock_pos or negedge reset_neg) begin
`endif
    if (!reset_neg) begin
      r_state <= STABLE_LOW;
      r_count <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end
`ifdef DEBOUNCE_PRESET_EN
    else if (!preset_neg) begin
      r_state <= STABLE_HIGH;
      r_count <= '0;
      r_out   <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end
`endif
    else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LOW: begin
          if (w_sync) begin
            r_state <= CHECK_HIGH;
            r_count <= CNT_ONE;
          end else begin
            r_count <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!w_sync) begin
            r_state <= STABLE_LOW;
            r_count <= '0;
          end else if (r_count == CNT_LAST) begin
            r_state <= STABLE_HIGH;
            r_out   <= 1'b1;
            r_rise  <= 1'b1;
            r_count <= '0;
          end else begin
            r_count <= r_count + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!w_sync) begin
            r_state <= CHECK_LOW;
            r_count <= CNT_ONE;
          end else begin
            r_count <= '0;
          end
        end
        CHECK_LOW: begin
          if (w_sync) begin
            r_state <= STABLE_HIGH;
            r_count <= '0;
          end else if (r_count == CNT_LAST) begin
            r_state <= STABLE_LOW;
            r_out   <= 1'b0;
            r_fall  <= 1'b1;
            r_count <= '0;
          end else begin
            r_count <= r_count + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign signal_out     = r_out;
  assign signal_out_neg = ~r_out;
  assign rise_pulse     = r_rise;
  assign fall_pulse     = r_fall;
endmodule
